// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered ALU slice: opcode type and encodings,
// the status-flag bundle, the flag value forced by reset, and a small helper
// that tells whether an opcode writes the result/flag registers.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADD  = 3'b000;
    localparam opcode_t OP_SUB  = 3'b001;
    localparam opcode_t OP_AND  = 3'b010;
    localparam opcode_t OP_OR   = 3'b011;
    localparam opcode_t OP_XOR  = 3'b100;
    localparam opcode_t OP_NAND = 3'b101;
    localparam opcode_t OP_SLT  = 3'b110;
    localparam opcode_t OP_NOP  = 3'b111;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } flags_t;

    // Reset leaves result at zero, so the zero flag must read as set.
    localparam flags_t FLAGS_RESET = '{zero: 1'b1, negative: 1'b0, carry: 1'b0, overflow: 1'b0};

    // NOP still pulses out_valid but must not disturb result or flags.
    function automatic logic op_writes_result(input opcode_t op);
        return (op != OP_NOP);
    endfunction

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
// Operand/result bundle between the operand register file (master) and the
// ALU (slave).
//   in_valid, a, b, op      : master -> slave, one operation per valid cycle
//   result, out_valid,
//   zero, negative,
//   carry, overflow         : slave -> master, registered, 1-cycle latency
// -----------------------------------------------------------------------------
interface alu_if #(
    parameter int WIDTH = 8
);
    import alu_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    opcode_t          op;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, op,
        input  result, out_valid, zero, negative, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, op,
        output result, out_valid, zero, negative, carry, overflow
    );

endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational datapath: computes the result and status flags for one
// operation. No state; the enclosing stage registers the outputs.
//   i_a, i_b  : operands (WIDTH bits)
//   i_op      : opcode (alu_pkg::opcode_t)
//   o_result  : operation result (zero for NOP; the caller holds instead)
//   o_flags   : {zero, negative, carry, overflow} for o_result
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  opcode_t          i_op,
    output logic [WIDTH-1:0] o_result,
    output flags_t           o_flags
);

    // One extra bit captures ADD carry-out and SUB borrow.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_lt_signed;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;

    assign w_sum       = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff      = {1'b0, i_a} - {1'b0, i_b};
    assign w_lt_signed = ($signed(i_a) < $signed(i_b));

    // Opcode decode: select result, carry and signed-overflow per operation.
    always_comb begin
        w_result   = {WIDTH{1'b0}};
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_result   = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                // Same-sign operands producing a different-sign sum.
                w_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_result   = w_diff[WIDTH-1:0];
                w_carry    = w_diff[WIDTH];
                // Opposite-sign operands where the difference flips away from a.
                w_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  w_result = i_a & i_b;
            OP_OR:   w_result = i_a | i_b;
            OP_XOR:  w_result = i_a ^ i_b;
            OP_NAND: w_result = ~(i_a & i_b);
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
            OP_NOP:  w_result = {WIDTH{1'b0}};
            default: w_result = {WIDTH{1'b0}};
        endcase
    end

    assign o_result = w_result;
    assign o_flags  = '{zero:     (w_result == {WIDTH{1'b0}}),
                        negative: w_result[WIDTH-1],
                        carry:    w_carry,
                        overflow: w_overflow};

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Registered WIDTH-bit ALU stage between the operand register file and
// writeback. Operands accepted on any edge with in_valid=1 produce result,
// flags and a one-cycle out_valid pulse after that edge. Idle cycles and NOP
// hold result/flags. No backpressure.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high; wins over in_valid
//   bus  : alu_if slave modport (operands in, registered result/flags out);
//          the interface WIDTH must equal this module's WIDTH (>= 2)
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] w_core_result;
    flags_t           w_core_flags;

    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;
    logic             r_out_valid;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a      (bus.a),
        .i_b      (bus.b),
        .i_op     (bus.op),
        .o_result (w_core_result),
        .o_flags  (w_core_flags)
    );

    // Output register stage: reset, capture on accepted op, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= {WIDTH{1'b0}};
            r_flags     <= FLAGS_RESET;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid && op_writes_result(bus.op)) begin
                r_result <= w_core_result;
                r_flags  <= w_core_flags;
            end else begin
                r_result <= r_result;
                r_flags  <= r_flags;
            end
        end
    end

    assign bus.result    = r_result;
    assign bus.out_valid = r_out_valid;
    assign bus.zero      = r_flags.zero;
    assign bus.negative  = r_flags.negative;
    assign bus.carry     = r_flags.carry;
    assign bus.overflow  = r_flags.overflow;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu (WIDTH=8). Directed vectors carry literal
// expectations; the random phase is checked against an integer-arithmetic
// reference model that tracks the expected output state cycle by cycle.
// -----------------------------------------------------------------------------
module tb_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } obs_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        obs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t m;                // model of the expected DUT outputs

    always #5 clk = ~clk;

    alu_if #(.WIDTH(8)) bus ();

    alu #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic obs_t observe();
        return {bus.out_valid, bus.result, bus.zero, bus.negative, bus.carry, bus.overflow};
    endfunction

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic obs_t ref_op(input int op, input int a, input int b);
        int   r;
        int   sa;
        int   sb;
        logic c;
        logic v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            0: begin r = (a + b) & 255; c = (a + b) > 255; v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin r = (a - b) & 255; c = (a < b);       v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (~(a & b)) & 255;
            6: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        return {1'b1, 8'(r), (r == 0), (r >= 128), c, v};
    endfunction

    // Apply one cycle of stimulus, advance past the edge, update the model.
    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic r);
        rst          = r;
        bus.in_valid = v;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        if (r) begin
            m = {1'b0, 8'h00, 4'b1000};
        end else if (v && op != 3'b111) begin
            m = ref_op(int'(op), int'(a), int'(b));
        end else begin
            m.valid = v;
        end
    endtask

    task automatic run_vectors(input string name, input vec_t vs[$]);
        obs_t got;
        foreach (vs[i]) begin
            drive(1'b1, vs[i].op, vs[i].a, vs[i].b, 1'b0);
            got = observe();
            n_checks++;
            if (got !== vs[i].exp) begin
                $display("FAIL %s[%0d] op=%b a=%h b=%h: got v=%b r=%h znco=%b%b%b%b, expected v=%b r=%h znco=%b%b%b%b",
                         name, i, vs[i].op, vs[i].a, vs[i].b,
                         got.valid, got.res, got.z, got.n, got.c, got.v,
                         vs[i].exp.valid, vs[i].exp.res, vs[i].exp.z, vs[i].exp.n, vs[i].exp.c, vs[i].exp.v);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        obs_t got;
        drive(1'b1, OP_ADD, 8'h12, 8'h34, 1'b1);
        drive(1'b1, OP_SUB, 8'h56, 8'h78, 1'b1);
        got = observe();
        n_checks++;
        if (got !== 13'({1'b0, 8'h00, 4'b1000})) begin
            $display("FAIL reset: got %b expected %b", got, 13'({1'b0, 8'h00, 4'b1000}));
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_arith();
        vec_t vs[$];
        vs.push_back('{OP_ADD, 8'h0A, 8'h03, {1'b1, 8'h0D, 4'b0000}});
        vs.push_back('{OP_SUB, 8'h0A, 8'h03, {1'b1, 8'h07, 4'b0000}});
        run_vectors("arith", vs);
    endtask

    task automatic test_logic();
        vec_t vs[$];
        vs.push_back('{OP_AND,  8'h0A, 8'h03, {1'b1, 8'h02, 4'b0000}});
        vs.push_back('{OP_OR,   8'h0A, 8'h03, {1'b1, 8'h0B, 4'b0000}});
        vs.push_back('{OP_XOR,  8'h0A, 8'h03, {1'b1, 8'h09, 4'b0000}});
        vs.push_back('{OP_NAND, 8'h0A, 8'h03, {1'b1, 8'hFD, 4'b0100}});
        run_vectors("logic", vs);
    endtask

    task automatic test_slt();
        vec_t vs[$];
        vs.push_back('{OP_SLT, 8'h0A, 8'h0F, {1'b1, 8'h01, 4'b0000}});
        vs.push_back('{OP_SLT, 8'h80, 8'h01, {1'b1, 8'h01, 4'b0000}});
        vs.push_back('{OP_SLT, 8'h0F, 8'h0A, {1'b1, 8'h00, 4'b1000}});
        run_vectors("slt", vs);
    endtask

    task automatic test_nop();
        vec_t vs[$];
        vs.push_back('{OP_ADD, 8'h0A, 8'h03, {1'b1, 8'h0D, 4'b0000}});
        vs.push_back('{OP_NOP, 8'hFF, 8'hFF, {1'b1, 8'h0D, 4'b0000}});
        run_vectors("nop", vs);
    endtask

    task automatic test_boundaries();
        vec_t vs[$];
        vs.push_back('{OP_ADD, 8'hFF, 8'h01, {1'b1, 8'h00, 4'b1010}});
        vs.push_back('{OP_ADD, 8'h7F, 8'h01, {1'b1, 8'h80, 4'b0101}});
        vs.push_back('{OP_SUB, 8'h00, 8'h01, {1'b1, 8'hFF, 4'b0110}});
        run_vectors("boundary", vs);
    endtask

    // Idle after SUB 00-01: out_valid drops, FF and its flags hold.
    task automatic test_idle();
        obs_t got;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 1'b0);
            got = observe();
            n_checks++;
            if (got !== 13'({1'b0, 8'hFF, 4'b0110})) begin
                $display("FAIL idle[%0d]: got %b expected %b", i, got, 13'({1'b0, 8'hFF, 4'b0110}));
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        obs_t got;
        drive(1'b1, OP_ADD, 8'h7F, 8'h01, 1'b0);
        drive(1'b1, OP_ADD, 8'h01, 8'h02, 1'b1);
        got = observe();
        n_checks++;
        if (got !== 13'({1'b0, 8'h00, 4'b1000})) begin
            $display("FAIL rst_with_op: got %b expected %b", got, 13'({1'b0, 8'h00, 4'b1000}));
        end else begin
            n_pass++;
        end
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
        got = observe();
        n_checks++;
        if (got !== 13'({1'b0, 8'h00, 4'b1000})) begin
            $display("FAIL rst_after: got %b expected %b", got, 13'({1'b0, 8'h00, 4'b1000}));
        end else begin
            n_pass++;
        end
    endtask

    // Back-to-back random traffic with idle gaps and occasional reset.
    task automatic test_random();
        obs_t       got;
        logic       v;
        logic       r;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 49) == 0);
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'h80;
            if ($urandom_range(0, 7) == 0) b = 8'h7F;
            drive(v, op, a, b, r);
            got = observe();
            n_checks++;
            if (got !== m) begin
                $display("FAIL random[%0d] v=%b rst=%b op=%b a=%h b=%h: got %b expected %b",
                         i, v, r, op, a, b, got, m);
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = OP_NOP;
        bus.a        = 8'h00;
        bus.b        = 8'h00;
        m            = {1'b0, 8'h00, 4'b1000};

        test_reset();
        test_arith();
        test_logic();
        test_slt();
        test_nop();
        test_boundaries();
        test_idle();
        test_reset_midstream();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
